ir_rx_sequencer: RTL and testbench
==================================

# ir_rx_sequencer

Controls the IR receive path between the IR receiver datapath and the host-side consumer. The receiver's `data_ready` stays high until the receiver is reset, so this block re-arms it by pulsing its reset after each frame. It holds the receiver off during a post-frame quiet window and drops runt frames. Accepted frames are queued in a 2-entry buffer with a valid/ready handshake toward the decoder or host interface.

## Interface
Parameters:
- `FRAME_W`, 128: width of the frame payload from the receiver.
- `LEN_W`, 33: width of the receiver's bit-count field.
- `ARM_CYC`, 4: cycles that `rx_rst_n` is held low to clear the receiver.
- `HOLDOFF_CYC`, 500000: post-frame quiet window (10 ms at 50 MHz). The receiver is held in reset for this time.
- `MIN_LEN`, 8: frames with length below this are dropped as runts.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: enable receive. While low, the receiver is held in reset.
- `rx_rst_n`, out, 1: reset to the receiver (active-low).
- `rx_data_ready`, in, 1: sticky frame-done flag from the receiver.
- `rx_data`, in, `FRAME_W`: frame payload from the receiver.
- `rx_len`, in, `LEN_W`: frame bit count from the receiver.
- `out_valid`, out, 1: head of the frame buffer is valid.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_data`, out, `FRAME_W`: payload of the head entry.
- `out_len`, out, 8: length of the head entry, saturated to 255.
- `busy`, out, 1: high in every state other than IDLE and LISTEN.
- `drop_cnt`, out, 8: frames lost because the buffer was full. Saturating.
- `runt_cnt`, out, 8: frames dropped because they were shorter than `MIN_LEN`. Saturating.

## Operation
States and transitions:
- **IDLE**: `rx_rst_n`=0. Moves to ARM when `en`=1.
- **ARM**: `rx_rst_n`=0 for `ARM_CYC` cycles, counted by a down-counter. Then moves to LISTEN.
- **LISTEN**: `rx_rst_n`=1. When `rx_data_ready`=1, moves to CAPTURE.
- **CAPTURE** (1 cycle): samples `rx_data` and `rx_len`.
  - If `rx_len < MIN_LEN`: increments `runt_cnt`.
  - Else if the buffer can accept a push: pushes the frame.
  - Else: increments `drop_cnt`.
  - Always moves to HOLDOFF.
- **HOLDOFF**: `rx_rst_n`=0 for `HOLDOFF_CYC` cycles, then moves to ARM.

Enable and reset:
- `en`=0 in any state moves to IDLE on the next cycle. A frame in progress is abandoned.
- Buffer contents and counters are retained when `en` falls.

Frame buffer:
- 2 entries, FIFO order.
- A pop occurs when `out_valid && out_ready`.
- A push is accepted when the buffer is not full, or when it is full and a pop occurs in the same cycle.
- A push into an empty buffer with a simultaneous `out_ready` does not bypass: `out_valid` rises on the following cycle.

Length and counter rules:
- `out_len` = `rx_len` if `rx_len` < 256, else 255.
- `drop_cnt` and `runt_cnt` hold at 255.

Reset values (when `rst_n`=0):
- State is IDLE.
- `rx_rst_n`=0, `out_valid`=0, `out_data`=0, `out_len`=0, `busy`=0, `drop_cnt`=0, `runt_cnt`=0.
- Buffer is empty; all timers are 0.

## Timing
- LISTEN samples `rx_data_ready`=1 in cycle N. The block is in CAPTURE in cycle N+1. If the buffer was empty, `out_valid`=1 in cycle N+2.
- `rx_rst_n` falls in the first cycle of HOLDOFF, i.e. N+2.
- Low time of `rx_rst_n` between consecutive LISTEN windows is exactly `HOLDOFF_CYC + ARM_CYC` cycles.
- From `en` rising in IDLE to entering LISTEN: `ARM_CYC`+1 cycles.
- `out_data` and `out_len` are stable while `out_valid`=1 and `out_ready`=0.
- All outputs are registered. There is no combinational path from `out_ready` to `out_valid`.
- Asynchronous reset takes effect mid-frame or mid-HOLDOFF immediately. The first post-reset arm sequence starts only once `en`=1.

## Structure
- Shared package `ir_pkg`:
  - state enum (IDLE, ARM, LISTEN, CAPTURE, HOLDOFF);
  - `IR_FRAME_W`=128 and `IR_LEN_W`=33;
  - default timing constants.
- Sub-module `ir_frame_fifo`: the 2-entry FIFO, parameterised on total entry width `FRAME_W+8`. It provides push, pop, full and empty with the simultaneous push/pop-when-full rule above.
- The FSM, timers and saturating counters live in the top level.

## Test plan
Use `ARM_CYC`=4 and `HOLDOFF_CYC`=20 in the bench.
- **Single frame.** Stimulus: `en`=1, then `rx_data_ready`=1 with `rx_len`=32 and `rx_data`=0xA5A5_1234. Required: `out_valid` high 2 cycles after the sample, `out_len`=32, payload matches. Then `rx_rst_n` stays low for exactly 24 cycles.
- **Runt.** Stimulus: `rx_len`=5. Required: `runt_cnt`=1, `out_valid` stays 0, HOLDOFF still entered.
- **Overflow.** Stimulus: 3 frames with `out_ready`=0. Required: frames 1 and 2 are buffered, `drop_cnt`=1. Draining yields frames 1 then 2 in order.
- **Full with simultaneous pop.** Stimulus: buffer full, `out_ready`=1 in the CAPTURE cycle. Required: new frame accepted, `drop_cnt` unchanged.
- **Long frame.** Stimulus: `rx_len`=128. Required: `out_len`=128. Stimulus: `rx_len`=300. Required: `out_len`=255.
- **Disable and reset mid-operation.** Stimulus: drop `en` in LISTEN. Required: `rx_rst_n`=0 next cycle, buffer retained. Stimulus: assert `rst_n` low during HOLDOFF. Required: all outputs return to reset values immediately.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: shared state encoding, widths and default timing for the IR receive sequencer.
package ir_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_LISTEN, ST_CAPTURE, ST_HOLDOFF} ir_state_e;
  localparam int IR_FRAME_W = 128;
  localparam int IR_LEN_W = 33;
  localparam int IR_OUT_LEN_W = 8;
  localparam int IR_ARM_CYC = 4;
  localparam int IR_HOLDOFF_CYC = 500000;
  localparam int IR_MIN_LEN = 8;
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (&c) ? c : c + 8'd1;
  endfunction
endpackage

// File: rtl/ir_rx_sequencer_if.sv
// ir_rx_sequencer_if: receiver-side and consumer-side signals of the IR receive sequencer.
interface ir_rx_sequencer_if import ir_pkg::*; #(
  parameter int FRAME_W = IR_FRAME_W,
  parameter int LEN_W = IR_LEN_W
) ();
  logic rx_rst_n;
  logic rx_data_ready;
  logic [FRAME_W-1:0] rx_data;
  logic [LEN_W-1:0] rx_len;
  logic out_valid;
  logic out_ready;
  logic [FRAME_W-1:0] out_data;
  logic [IR_OUT_LEN_W-1:0] out_len;
  modport master (output rx_rst_n, out_valid, out_data, out_len,
                  input rx_data_ready, rx_data, rx_len, out_ready);
  modport slave (input rx_rst_n, out_valid, out_data, out_len,
                 output rx_data_ready, rx_data, rx_len, out_ready);
endinterface

// File: rtl/ir_frame_fifo.sv
// ir_frame_fifo: 2-entry shift FIFO whose head register drives the output directly.
module ir_frame_fifo import ir_pkg::*; #(
  parameter int W = IR_FRAME_W + IR_OUT_LEN_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic full_o,
  output logic empty_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic rd, wr;
  assign rd = pop_i && cnt_q != 2'd0;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign wr = push_i && (cnt_q != 2'd2 || rd);
  always_comb begin
    head_d = rd ? tail_q : head_q;
    tail_d = tail_q;
    cnt_d = cnt_q + {1'b0, wr} - {1'b0, rd};
    if (wr && cnt_d == 2'd1) head_d = din_i;
    if (wr && cnt_d == 2'd2) tail_d = din_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
    end
  assign dout_o = head_q;
  assign full_o = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
endmodule

// File: rtl/ir_rx_sequencer.sv
// ir_rx_sequencer: re-arms the IR receiver after each frame, filters runts and queues frames for the host.
module ir_rx_sequencer import ir_pkg::*; #(
  parameter int FRAME_W = IR_FRAME_W,
  parameter int LEN_W = IR_LEN_W,
  parameter int ARM_CYC = IR_ARM_CYC,
  parameter int HOLDOFF_CYC = IR_HOLDOFF_CYC,
  parameter int MIN_LEN = IR_MIN_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  ir_rx_sequencer_if.master bus,
  output logic busy,
  output logic [7:0] drop_cnt,
  output logic [7:0] runt_cnt
);
  localparam int TW = $clog2((ARM_CYC > HOLDOFF_CYC ? ARM_CYC : HOLDOFF_CYC) + 1);
  localparam logic [TW-1:0] ARM_LD = TW'(ARM_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLDOFF_CYC - 1);
  ir_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic rx_rst_n_q, busy_q;
  logic [7:0] drop_q, runt_q, len_sat;
  logic [FRAME_W+7:0] fifo_dout;
  logic full, empty, capture, runt, push, pop;
  assign capture = en && state_q == ST_CAPTURE;
  assign runt = capture && bus.rx_len < LEN_W'(MIN_LEN);
  assign push = capture && !runt;
  assign pop = !empty && bus.out_ready;
  assign len_sat = (|bus.rx_len[LEN_W-1:8]) ? 8'hff : bus.rx_len[7:0];
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (!en) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          timer_d = ARM_LD;
        end
        ST_ARM: begin
          state_d = timer_q == '0 ? ST_LISTEN : ST_ARM;
          timer_d = timer_q == '0 ? timer_q : timer_q - TW'(1);
        end
        ST_LISTEN: state_d = bus.rx_data_ready ? ST_CAPTURE : ST_LISTEN;
        ST_CAPTURE: begin
          state_d = ST_HOLDOFF;
          timer_d = HOLD_LD;
        end
        ST_HOLDOFF: begin
          state_d = timer_q == '0 ? ST_ARM : ST_HOLDOFF;
          timer_d = timer_q == '0 ? ARM_LD : timer_q - TW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rx_rst_n_q <= 1'b0;
      busy_q <= 1'b0;
      drop_q <= '0;
      runt_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rx_rst_n_q <= state_d inside {ST_LISTEN, ST_CAPTURE};
      busy_q <= !(state_d inside {ST_IDLE, ST_LISTEN});
      if (runt) runt_q <= sat_inc(runt_q);
      if (push && full && !pop) drop_q <= sat_inc(drop_q);
    end
  ir_frame_fifo #(.W(FRAME_W + 8)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(push),
    .pop_i(pop),
    .din_i({len_sat, bus.rx_data}),
    .dout_o(fifo_dout),
    .full_o(full),
    .empty_o(empty)
  );
  assign bus.rx_rst_n = rx_rst_n_q;
  assign bus.out_valid = !empty;
  assign bus.out_len = fifo_dout[FRAME_W+7:FRAME_W];
  assign bus.out_data = fifo_dout[FRAME_W-1:0];
  assign busy = busy_q;
  assign drop_cnt = drop_q;
  assign runt_cnt = runt_q;
endmodule

// File: tb/tb_ir_rx_sequencer.sv
// tb_ir_rx_sequencer: directed plus randomized frames checked against a queue-based model of the sequencer.
module tb_ir_rx_sequencer;
  typedef struct packed {
    logic [7:0] len;
    logic [127:0] data;
  } frame_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic busy;
  logic [7:0] drop_cnt, runt_cnt;
  frame_t mq[$];
  int m_drop = 0, m_runt = 0;
  int n_chk = 0, n_pass = 0;
  ir_rx_sequencer_if #(.FRAME_W(128), .LEN_W(33)) bus ();
  ir_rx_sequencer #(.FRAME_W(128), .LEN_W(33), .ARM_CYC(4), .HOLDOFF_CYC(20), .MIN_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus.master),
    .busy(busy), .drop_cnt(drop_cnt), .runt_cnt(runt_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic exp_outputs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk({tag, "_data"}, bus.out_data, mq[0].data);
      chk({tag, "_len"}, bus.out_len, mq[0].len);
    end
    chk({tag, "_drop"}, drop_cnt, m_drop);
    chk({tag, "_runt"}, runt_cnt, m_runt);
  endtask
  task automatic wait_listen();
    int k = 0;
    while (bus.rx_rst_n !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("listen_reached", k < 200, 1'b1);
  endtask
  task automatic send(input logic [127:0] d, input logic [32:0] l, input logic rdy);
    wait_listen();
    bus.rx_data_ready = 1'b1;
    bus.rx_data = d;
    bus.rx_len = l;
    tick();
    chk("capture_busy", busy, 1'b1);
    chk("capture_rx_rst_n", bus.rx_rst_n, 1'b1);
    chk("capture_valid", bus.out_valid, mq.size() != 0);
    bus.out_ready = rdy;
    if (rdy && mq.size() != 0) begin
      chk("capture_pop_data", bus.out_data, mq[0].data);
      void'(mq.pop_front());
    end
    if (l < 8) m_runt = m_runt < 255 ? m_runt + 1 : 255;
    else if (mq.size() < 2) mq.push_back({(l > 255) ? 8'hff : l[7:0], d});
    else m_drop = m_drop < 255 ? m_drop + 1 : 255;
    tick();
    bus.rx_data_ready = 1'b0;
    bus.out_ready = 1'b0;
    chk("holdoff_rx_rst_n", bus.rx_rst_n, 1'b0);
    chk("holdoff_busy", busy, 1'b1);
    exp_outputs("post_capture");
  endtask
  task automatic drain(input int n);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", bus.out_valid, 1'b1);
      if (mq.size() != 0) begin
        chk("drain_data", bus.out_data, mq[0].data);
        chk("drain_len", bus.out_len, mq[0].len);
        void'(mq.pop_front());
      end
      tick();
    end
    bus.out_ready = 1'b0;
    exp_outputs("drained");
  endtask
  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    int k;
    logic [32:0] l;
    bus.rx_data_ready = 1'b0;
    bus.rx_data = '0;
    bus.rx_len = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_rx_rst_n", bus.rx_rst_n, 1'b0);
    chk("rst_out_data", bus.out_data, 128'h0);
    chk("rst_out_len", bus.out_len, 8'h0);
    chk("rst_busy", busy, 1'b0);
    exp_outputs("rst");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_rx_rst_n", bus.rx_rst_n, 1'b0);
    chk("idle_busy", busy, 1'b0);
    en = 1'b1;
    k = 0;
    tick();
    k++;
    chk("arm_busy", busy, 1'b1);
    while (bus.rx_rst_n !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("en_to_listen", k, 5);
    // single frame, then the quiet window length
    send(128'hA5A5_1234, 33'd32, 1'b0);
    k = 0;
    while (bus.rx_rst_n === 1'b0 && k < 200) begin
      tick();
      k++;
    end
    chk("rx_rst_n_low_time", k, 24);
    drain(1);
    send(rnd_data(), 33'd5, 1'b0);
    // overflow: three frames against a stalled consumer
    for (int i = 0; i < 3; i++) send(rnd_data(), 33'($urandom_range(8, 200)), 1'b0);
    chk("overflow_drop", drop_cnt, 8'd1);
    drain(2);
    // full buffer with a pop in the capture cycle
    send(rnd_data(), 33'd64, 1'b0);
    send(rnd_data(), 33'd65, 1'b0);
    send(rnd_data(), 33'd66, 1'b1);
    chk("full_pop_drop", drop_cnt, 8'd1);
    drain(2);
    send(rnd_data(), 33'd128, 1'b0);
    send(rnd_data(), 33'd300, 1'b0);
    drain(2);
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0: l = 33'($urandom_range(0, 7));
        1: l = 33'($urandom_range(8, 255));
        2: l = {1'($urandom_range(0, 1)), 32'($urandom)};
        default: l = 33'($urandom_range(256, 400));
      endcase
      send(rnd_data(), l, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) drain($urandom_range(0, mq.size()));
    end
    // disable while listening keeps the buffer
    if (mq.size() == 0) send(rnd_data(), 33'd40, 1'b0);
    wait_listen();
    en = 1'b0;
    tick();
    chk("disable_rx_rst_n", bus.rx_rst_n, 1'b0);
    chk("disable_busy", busy, 1'b0);
    repeat (5) tick();
    exp_outputs("disabled");
    en = 1'b1;
    send(rnd_data(), 33'd90, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    mq.delete();
    m_drop = 0;
    m_runt = 0;
    chk("async_rx_rst_n", bus.rx_rst_n, 1'b0);
    chk("async_out_data", bus.out_data, 128'h0);
    chk("async_out_len", bus.out_len, 8'h0);
    chk("async_busy", busy, 1'b0);
    exp_outputs("async");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_no_arm", bus.rx_rst_n, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
